// File: rtl/commit_trace_if.sv
// commit_trace_if: valid/ready trace port between the commit monitor and its consumer.
interface commit_trace_if #(parameter int DATA_W = 16);
    logic              trc_valid;
    logic              trc_ready;
    logic [1:0]        trc_type;
    logic [DATA_W-1:0] trc_a;
    logic [DATA_W-1:0] trc_d;
    modport master(output trc_valid, trc_type, trc_a, trc_d, input trc_ready);
    modport slave(input trc_valid, trc_type, trc_a, trc_d, output trc_ready);
endinterface

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: retire counters plus a multi-push trace FIFO drained over a valid/ready port.
module commit_trace_monitor #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              hlt,
    commit_trace_if.master    trc,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              halted,
    output logic              timeout,
    output logic              done
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, nextState;
    logic [AW:0] wrPtr, rdPtr, used, free;
    logic [AW-1:0] idxReg, idxLoad, idxStore;
    logic [1:0] nEv, off1, off2;
    logic capture, push, drop, pop, hitLimit;
    logic [1:0]        memType [DEPTH];
    logic [DATA_W-1:0] memA [DEPTH];
    logic [DATA_W-1:0] memD [DEPTH];

    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] x, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, x} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        capture   = state == RUN;
        nEv       = 2'(wb_regwrite) + 2'(mem_read) + 2'(mem_write);
        used      = wrPtr - rdPtr;
        // free space is taken before any same-cycle pop, so a full FIFO drops even while draining
        free      = (AW+1)'(DEPTH) - used;
        push      = capture && nEv != 2'd0 && (AW+1)'(nEv) <= free;
        drop      = capture && (AW+1)'(nEv) > free;
        pop       = trc.trc_valid & trc.trc_ready;
        hitLimit  = capture && cycle_count == CNT_W'(TIMEOUT - 1);
        off1      = {1'b0, wb_regwrite};
        off2      = off1 + {1'b0, mem_read};
        idxReg    = wrPtr[AW-1:0];
        idxLoad   = wrPtr[AW-1:0] + AW'(off1);
        idxStore  = wrPtr[AW-1:0] + AW'(off2);
        nextState = (state == IDLE && en) ? RUN :
                    (capture && (hlt || hitLimit)) ? DRAIN :
                    (state == DRAIN && used == '0) ? DONE : state;
    end

    assign trc.trc_valid = used != '0;
    assign trc.trc_type  = memType[rdPtr[AW-1:0]];
    assign trc.trc_a     = memA[rdPtr[AW-1:0]];
    assign trc.trc_d     = memD[rdPtr[AW-1:0]];
    assign done          = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wrPtr       <= '0;
            rdPtr       <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state <= nextState;
            if (push) wrPtr <= wrPtr + (AW+1)'(nEv);
            if (pop) rdPtr <= rdPtr + 1'b1;
            if (capture) begin
                cycle_count <= satAdd(cycle_count, 2'd1);
                inst_count  <= satAdd(inst_count, 2'(hlt | wb_regwrite | mem_write));
                if (hlt) halted <= 1'b1;
                if (hitLimit) timeout <= 1'b1;
            end
            if (drop) drop_count <= satAdd(drop_count, nEv);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (wb_regwrite) begin
                memType[idxReg] <= 2'd0;
                memA[idxReg]    <= DATA_W'(wb_reg);
                memD[idxReg]    <= wb_data;
            end
            if (mem_read) begin
                memType[idxLoad] <= 2'd1;
                memA[idxLoad]    <= mem_addr;
                memD[idxLoad]    <= mem_rdata;
            end
            if (mem_write) begin
                memType[idxStore] <= 2'd2;
                memA[idxStore]    <= mem_addr;
                memD[idxStore]    <= mem_wdata;
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb_commit_trace_monitor: directed checks of counters, trace ordering, overflow, timeout and async reset.
module tb_commit_trace_monitor;
    logic clk = 1'b0;
    logic rst_n, en, wb_regwrite, mem_read, mem_write, hlt;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] cycle_count, inst_count, drop_count;
    logic halted, timeout, done;
    int tests = 0;
    int failed = 0;

    commit_trace_if #(.DATA_W(16)) trc();

    commit_trace_monitor #(.DATA_W(16), .REG_W(4), .DEPTH(8), .CNT_W(32), .TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wb_regwrite(wb_regwrite), .wb_reg(wb_reg),
        .wb_data(wb_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt), .trc(trc),
        .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
        .halted(halted), .timeout(timeout), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; wb_regwrite = 0; mem_read = 0; mem_write = 0; hlt = 0;
        wb_reg = 0; wb_data = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
        trc.trc_ready = 0;
    endtask

    task automatic restart();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
        en = 1;
        step();
        en = 0;
    endtask

    task automatic popHead(input string tag, input logic [1:0] ty, input logic [15:0] a, input logic [15:0] d);
        chk({tag, "_valid"}, 32'(trc.trc_valid), 1);
        chk({tag, "_type"}, 32'(trc.trc_type), 32'(ty));
        chk({tag, "_a"}, 32'(trc.trc_a), 32'(a));
        chk({tag, "_d"}, 32'(trc.trc_d), 32'(d));
        trc.trc_ready = 1;
        step();
        trc.trc_ready = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #12;
        chk("rst_valid", 32'(trc.trc_valid), 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_inst", inst_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_flags", {29'd0, halted, timeout, done}, 0);
        rst_n = 1;

        // three register writes then halt
        restart();
        wb_regwrite = 1; wb_reg = 5; wb_data = 16'h1234;
        repeat (3) step();
        wb_regwrite = 0; hlt = 1;
        step();
        hlt = 0;
        chk("t1_inst", inst_count, 4);
        chk("t1_cycle", cycle_count, 4);
        chk("t1_halted", 32'(halted), 1);
        chk("t1_timeout", 32'(timeout), 0);
        for (int i = 0; i < 3; i++) popHead("t1_reg", 2'd0, 16'd5, 16'h1234);
        chk("t1_empty", 32'(trc.trc_valid), 0);
        chk("t1_notdone", 32'(done), 0);
        step();
        chk("t1_done", 32'(done), 1);

        // one cycle with all three events
        restart();
        wb_regwrite = 1; wb_reg = 3; wb_data = 16'hAAAA;
        mem_read = 1; mem_write = 1; mem_addr = 16'h0040; mem_wdata = 16'hBEEF; mem_rdata = 16'hCAFE;
        step();
        idle();
        chk("t2_inst", inst_count, 1);
        popHead("t2_reg", 2'd0, 16'd3, 16'hAAAA);
        popHead("t2_load", 2'd1, 16'h0040, 16'hCAFE);
        popHead("t2_store", 2'd2, 16'h0040, 16'hBEEF);
        chk("t2_empty", 32'(trc.trc_valid), 0);

        // overflow: 7 entries, 3-event cycle dropped, single event fills, then full+pop drops
        restart();
        for (int i = 0; i < 7; i++) begin
            wb_regwrite = 1; wb_reg = 4'(i); wb_data = 16'(i * 16);
            step();
        end
        wb_reg = 7; mem_read = 1; mem_write = 1; mem_addr = 16'h0100;
        step();
        chk("t3_drop3", drop_count, 3);
        chk("t3_inst8", inst_count, 8);
        mem_read = 0; mem_write = 0; wb_reg = 9; wb_data = 16'h0090;
        step();
        chk("t3_drop_after_fill", drop_count, 3);
        wb_reg = 10; wb_data = 16'h00A0; trc.trc_ready = 1;
        step();
        idle();
        chk("t5_drop4", drop_count, 4);
        chk("t4b_timeout", 32'(timeout), 1);
        chk("t4b_cycle", cycle_count, 10);
        chk("t4b_halted", 32'(halted), 0);
        for (int i = 1; i < 7; i++) popHead("t5_drain", 2'd0, 16'(i), 16'(i * 16));
        popHead("t3_last", 2'd0, 16'd9, 16'h0090);
        chk("t5_empty", 32'(trc.trc_valid), 0);
        step();
        chk("t3_done", 32'(done), 1);

        // timeout with no events
        restart();
        repeat (9) step();
        chk("t4_cycle9", cycle_count, 9);
        chk("t4_timeout_early", 32'(timeout), 0);
        step();
        chk("t4_cycle10", cycle_count, 10);
        chk("t4_timeout", 32'(timeout), 1);
        chk("t4_halted", 32'(halted), 0);
        chk("t4_inst", inst_count, 0);
        step();
        chk("t4_done", 32'(done), 1);
        chk("t4_cycle_hold", cycle_count, 10);

        // asynchronous reset mid-run
        restart();
        wb_regwrite = 1; wb_reg = 2; wb_data = 16'h0022;
        repeat (5) step();
        chk("t6_valid_before", 32'(trc.trc_valid), 1);
        #2 rst_n = 0;
        #1;
        chk("t6_valid", 32'(trc.trc_valid), 0);
        chk("t6_cycle", cycle_count, 0);
        chk("t6_inst", inst_count, 0);
        rst_n = 1;
        step();
        step();
        chk("t6_idle_cycle", cycle_count, 0);
        chk("t6_idle_valid", 32'(trc.trc_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
